// File: rtl/stimulus_recorder.sv
// stimulus_recorder
//   Records the live taillight control inputs into a small sample memory at
//   the slow stimulus tick rate, then replays the captured sequence in a loop
//   onto the 4-bit stimulus bus (same bus as the canned ROM q).
//
// Ports
//   clock     system clock
//   reset_n   asynchronous active-low reset
//   rec_req   record request level; rising edge starts a recording
//   play_en   level; high requests looped playback of a held recording
//   din       live sample {KEY1, SW2, SW1, SW0}, already synchronised
//   q         registered playback stimulus (0 outside PLAY)
//   addr      current memory pointer
//   state     FSM state for the debug display (IDLE=0 ARM=1 REC=2 FULL=3 PLAY=4)
//   busy      high while arming or recording
//   rec_done  high while a complete recording is held
module stimulus_recorder #(
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 5000000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rec_req,
  input  logic              play_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] addr,
  output logic [2:0]        state,
  output logic              busy,
  output logic              rec_done
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ARM  = 3'd1;
  localparam logic [2:0] REC  = 3'd2;
  localparam logic [2:0] FULL = 3'd3;
  localparam logic [2:0] PLAY = 3'd4;

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rec_req_d_q;
  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic              done_q, done_d;
  logic              tick, rec_rise, mem_we;

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Free-running divider; never restarted by the FSM so sample spacing is
  // always one full period regardless of when a recording is requested.
  assign tick     = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign rec_rise = rec_req & ~rec_req_d_q;

  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    state_d = state_q;
    addr_d  = addr_q;
    done_d  = done_q;
    mem_we  = 1'b0;
    // q only carries data in PLAY; any path out of PLAY lands on 0.
    out_d   = (state_q == PLAY) ? out_q : '0;
    case (state_q)
      IDLE: begin
        if (rec_rise) begin
          state_d = ARM;
        end else if (play_en && done_q) begin
          state_d = PLAY;
          addr_d  = '0;
        end
      end
      ARM: begin
        // Old recording is invalid from here on; the tick that leaves ARM
        // only aligns the first sample and does not write.
        done_d = 1'b0;
        addr_d = '0;
        if (tick) state_d = REC;
      end
      REC: begin
        if (tick) begin
          mem_we = 1'b1;
          addr_d = addr_q + 1'b1;
          if (addr_q == ADDR_W'(DEPTH - 1)) begin
            done_d  = 1'b1;
            state_d = FULL;
          end
        end
      end
      FULL: begin
        if (rec_rise) begin
          state_d = ARM;
        end else if (play_en) begin
          state_d = PLAY;
          addr_d  = '0;
        end
      end
      PLAY: begin
        if (rec_rise) begin
          state_d = ARM;
          out_d   = '0;
        end else if (!play_en) begin
          state_d = FULL;
          out_d   = '0;
        end else if (tick) begin
          out_d  = mem_q[addr_q];
          addr_d = addr_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        out_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      rec_req_d_q <= 1'b0;
      state_q     <= IDLE;
      addr_q      <= '0;
      out_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      rec_req_d_q <= rec_req;
      state_q     <= state_d;
      addr_q      <= addr_d;
      out_q       <= out_d;
      done_q      <= done_d;
    end
  end

  // Sample store is left uncleared by reset; done_q gates its use.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[addr_q] <= din;
  end

  assign q        = out_q;
  assign addr     = addr_q;
  assign state    = state_q;
  assign busy     = (state_q == ARM) | (state_q == REC);
  assign rec_done = done_q;

endmodule

// File: tb/tb_stimulus_recorder.sv
// Self-checking bench for stimulus_recorder with a short tick period.
// Expected behaviour comes from the bench's own cycle count (tick edges fall
// on every TD-th clock after reset release) and from arrays of the samples
// it drove during recording.
module tb_stimulus_recorder;
  localparam int TD = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       rec_req = 1'b0;
  logic       play_en = 1'b0;
  logic [3:0] din = 4'd0;
  logic [3:0] q;
  logic [2:0] addr;
  logic [2:0] state;
  logic       busy;
  logic       rec_done;

  stimulus_recorder #(.DEPTH(8), .ADDR_W(3), .DATA_W(4), .TICK_DIV(TD)) dut (
    .clock(clock), .reset_n(reset_n), .rec_req(rec_req), .play_en(play_en),
    .din(din), .q(q), .addr(addr), .state(state), .busy(busy),
    .rec_done(rec_done)
  );

  always #5 clock = ~clock;

  // Clock edges since reset release; edge numbers divisible by TD are tick edges.
  int cyc;
  always @(posedge clock or negedge reset_n)
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;

  int errs = 0;
  int checks = 0;
  logic [3:0] exp_mem [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Advance to just after the next tick edge; on the cycles before it, the
  // outputs must hold (negative expected value = don't care).
  task automatic to_tick(input string tag, input int es, input int eq, input int ea, input int ed);
    bool_loop: for (int n = 0; n < 2 * TD; n++) begin
      step();
      if (cyc % TD == 0) break;
      chk({tag, "_state"}, 32'(state), 32'(es));
      if (eq >= 0) chk({tag, "_q"}, 32'(q), 32'(eq));
      if (ea >= 0) chk({tag, "_addr"}, 32'(addr), 32'(ea));
      if (ed >= 0) chk({tag, "_done"}, 32'(rec_done), 32'(ed));
    end
  endtask

  task automatic start_rec(input bit with_play);
    rec_req = 1'b1;
    if (with_play) play_en = 1'b1;
    step();
    rec_req = 1'b0;
    play_en = 1'b0;
    chk("arm_state", 32'(state), 32'd1);
    chk("arm_busy", 32'(busy), 32'd1);
    chk("arm_q", 32'(q), 32'd0);
  endtask

  task automatic rec_body(input int nw, input bit toggle);
    to_tick("arm", 1, 0, -1, 0);
    chk("rec_entry_state", 32'(state), 32'd2);
    chk("rec_entry_addr", 32'(addr), 32'd0);
    chk("rec_entry_done", 32'(rec_done), 32'd0);
    for (int i = 0; i < nw; i++) begin
      din = exp_mem[i];
      if (toggle && (i == 2 || i == 5)) begin
        rec_req = 1'b1;
        step();
        rec_req = 1'b0;
      end
      to_tick("rec", 2, 0, i, 0);
      if (i < 7) begin
        chk("rec_state", 32'(state), 32'd2);
        chk("rec_addr", 32'(addr), 32'(i + 1));
      end else begin
        chk("full_state", 32'(state), 32'd3);
        chk("full_addr", 32'(addr), 32'd0);
        chk("full_done", 32'(rec_done), 32'd1);
        chk("full_busy", 32'(busy), 32'd0);
      end
    end
  endtask

  task automatic play(input int nticks);
    play_en = 1'b1;
    step();
    chk("play_state", 32'(state), 32'd4);
    chk("play_q0", 32'(q), 32'd0);
    chk("play_addr0", 32'(addr), 32'd0);
    for (int k = 0; k < nticks; k++) begin
      to_tick("play", 4, (k == 0) ? 0 : int'(exp_mem[(k - 1) % 8]), k % 8, 1);
      chk("play_q", 32'(q), 32'(exp_mem[k % 8]));
      chk("play_addr", 32'(addr), 32'((k + 1) % 8));
    end
    play_en = 1'b0;
    step();
    chk("stop_q", 32'(q), 32'd0);
    chk("stop_state", 32'(state), 32'd3);
  endtask

  initial begin
    step();
    step();
    chk("rst_q", 32'(q), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_done", 32'(rec_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Recording of 1..8 started right at reset release: first tick edge is
    // the 4th clock, so ARM must hold through clocks 1..3.
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) exp_mem[i] = 4'(i + 1);
    start_rec(1'b0);
    rec_body(8, 1'b0);
    play(10);

    // rec_req and play_en rising together in FULL: record wins.
    for (int i = 0; i < 8; i++) exp_mem[i] = 4'($urandom_range(0, 15));
    start_rec(1'b1);
    rec_body(8, 1'b1);
    play(9);

    // Reset mid-recording invalidates everything.
    for (int i = 0; i < 8; i++) exp_mem[i] = 4'($urandom_range(0, 15));
    start_rec(1'b0);
    rec_body(3, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("abort_state", 32'(state), 32'd0);
    chk("abort_done", 32'(rec_done), 32'd0);
    chk("abort_addr", 32'(addr), 32'd0);
    chk("abort_q", 32'(q), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    play_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("noplay_state", 32'(state), 32'd0);
      chk("noplay_q", 32'(q), 32'd0);
    end
    play_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
